// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with a standard or first-word-fall-through read port, occupancy
// flags, sticky overflow/underflow and a peak-occupancy watermark.
module sync_fifo_fwft #(
  parameter int FIFO_PTR         = 10,
  parameter int FIFO_WIDTH       = 32,
  parameter int FIFO_DEPTH       = 1024,
  parameter int ALMOST_FULL_GAP  = 6,
  parameter int ALMOST_EMPTY_GAP = 6,
  parameter int FWFT_MODE        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [FIFO_WIDTH-1:0] write_data,
  input  logic                  read_en,
  output logic [FIFO_WIDTH-1:0] read_data,
  output logic                  read_valid,
  input  logic                  clear_err,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic [FIFO_PTR:0]     fifo_data_count,
  output logic [FIFO_PTR:0]     fifo_free_count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [FIFO_PTR:0]     max_level
);

  localparam int                  CW       = FIFO_PTR + 1;
  localparam logic [CW-1:0]       DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]       AF_C     = CW'(ALMOST_FULL_GAP);
  localparam logic [CW-1:0]       AE_C     = CW'(ALMOST_EMPTY_GAP);
  localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
  localparam logic [FIFO_PTR-1:0] PTR_LAST = FIFO_PTR'(FIFO_DEPTH - 1);
  localparam logic [FIFO_PTR-1:0] PTR_ONE  = FIFO_PTR'(1);
  localparam bit                  FWFT     = (FWFT_MODE != 0);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] r_ram_q;
  logic [FIFO_WIDTH-1:0] r_read_data;
  logic [FIFO_PTR-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count, r_free, r_max;
  logic                  r_full, r_empty, r_afull, r_aempty;
  logic                  r_read_valid, r_ram_vld, r_ovf, r_udf;

  logic                  w_wr_acc, w_wr_rej, w_rd_acc, w_rd_rej;
  logic                  w_mem_avail, w_mem_rd, w_out_load;
  logic [CW-1:0]         w_count_next, w_free_next;

  // Handshake: write_en is accepted only while fifo_full is low, read_en only while
  // fifo_empty is low (FWFT: while read_valid is high); a rejected request changes
  // nothing except setting its sticky error flag.
  // FWFT words move memory -> r_ram_q -> read_data; each stage refills when empty or
  // draining, which gives two-edge fill latency and one pop per cycle.
  always_comb begin
    w_wr_acc    = write_en && !r_full;
    w_wr_rej    = write_en && r_full;
    w_rd_acc    = 1'b0;
    w_rd_rej    = 1'b0;
    w_mem_avail = 1'b0;
    w_out_load  = 1'b0;
    w_mem_rd    = 1'b0;
    if (FWFT) begin
      w_rd_acc    = read_en && r_read_valid;
      w_rd_rej    = read_en && !r_read_valid;
      w_mem_avail = r_count > (CW'(r_ram_vld) + CW'(r_read_valid));
      w_out_load  = r_ram_vld && (!r_read_valid || w_rd_acc);
      w_mem_rd    = w_mem_avail && (!r_ram_vld || w_out_load);
    end else begin
      w_rd_acc = read_en && !r_empty;
      w_rd_rej = read_en && r_empty;
      w_mem_rd = w_rd_acc;
    end
    w_count_next = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_next = r_count + CNT_ONE;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_next = r_count - CNT_ONE;
    end
    w_free_next = DEPTH_C - w_count_next;
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_wr_acc) r_mem[r_wr_ptr] <= write_data;
    if (FWFT && w_mem_rd) r_ram_q <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_free       <= DEPTH_C;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_afull      <= (DEPTH_C <= AF_C);
      r_aempty     <= 1'b1;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_ram_vld    <= 1'b0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_max        <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_ONE;
      if (w_mem_rd) r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_ONE;
      r_count  <= w_count_next;
      r_free   <= w_free_next;
      r_full   <= (w_count_next == DEPTH_C);
      r_empty  <= (w_count_next == '0);
      r_afull  <= (w_free_next <= AF_C);
      r_aempty <= (w_count_next <= AE_C);
      if (FWFT) begin
        if (w_out_load) r_read_data <= r_ram_q;
        r_read_valid <= w_out_load || (r_read_valid && !w_rd_acc);
        r_ram_vld    <= w_mem_rd || (r_ram_vld && !w_out_load);
      end else begin
        if (w_rd_acc) r_read_data <= r_mem[r_rd_ptr];
        r_read_valid <= w_rd_acc;
        r_ram_vld    <= 1'b0;
      end
      // A new error event wins over clear_err in the same cycle.
      r_ovf <= w_wr_rej || (r_ovf && !clear_err);
      r_udf <= w_rd_rej || (r_udf && !clear_err);
      if (clear_err || (w_count_next > r_max)) r_max <= w_count_next;
    end
  end

  assign read_data         = r_read_data;
  assign read_valid        = r_read_valid;
  assign fifo_full         = r_full;
  assign fifo_empty        = FWFT ? !r_read_valid : r_empty;
  assign fifo_almost_full  = r_afull;
  assign fifo_almost_empty = r_aempty;
  assign fifo_data_count   = r_count;
  assign fifo_free_count   = r_free;
  assign overflow          = r_ovf;
  assign underflow         = r_udf;
  assign max_level         = r_max;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: one standard-read and one FWFT instance share stimulus and
// are checked every cycle against a queue-based model, plus directed tables/sequences.
module tb_sync_fifo_fwft;

  localparam int PTR   = 3;
  localparam int W     = 8;
  localparam int DEPTH = 6;
  localparam int AFG   = 2;
  localparam int AEG   = 1;
  localparam int NV    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, write_en, read_en, clear_err;
  logic [W-1:0] write_data;
  logic [W-1:0] o_rd [2];
  logic         o_rv [2], o_full [2], o_empty [2], o_af [2], o_ae [2], o_ovf [2], o_udf [2];
  logic [PTR:0] o_cnt [2], o_free [2], o_max [2];

  sync_fifo_fwft #(.FIFO_PTR(PTR), .FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH),
    .ALMOST_FULL_GAP(AFG), .ALMOST_EMPTY_GAP(AEG), .FWFT_MODE(0)) u_std (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(o_rd[0]), .read_valid(o_rv[0]), .clear_err(clear_err),
    .fifo_full(o_full[0]), .fifo_empty(o_empty[0]), .fifo_almost_full(o_af[0]),
    .fifo_almost_empty(o_ae[0]), .fifo_data_count(o_cnt[0]), .fifo_free_count(o_free[0]),
    .overflow(o_ovf[0]), .underflow(o_udf[0]), .max_level(o_max[0]));

  sync_fifo_fwft #(.FIFO_PTR(PTR), .FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH),
    .ALMOST_FULL_GAP(AFG), .ALMOST_EMPTY_GAP(AEG), .FWFT_MODE(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(o_rd[1]), .read_valid(o_rv[1]), .clear_err(clear_err),
    .fifo_full(o_full[1]), .fifo_empty(o_empty[1]), .fifo_almost_full(o_af[1]),
    .fifo_almost_empty(o_ae[1]), .fifo_data_count(o_cnt[1]), .fifo_free_count(o_free[1]),
    .overflow(o_ovf[1]), .underflow(o_udf[1]), .max_level(o_max[1]));

  // Reference model: words held per instance; FWFT words carry the edge at which they
  // become visible (two edges after the write).
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int           rdy_q1[$];
  int           cyc = 0;
  logic [W-1:0] m_rd0 = '0;
  int           m_rv0 = 0;
  int           m_ovf [2], m_udf [2], m_max [2];
  int           checks = 0;
  int           failures = 0;

  typedef struct {
    int we; int wd; int re; int clr;
    int cnt; int full; int empty; int af; int ae; int ovf; int udf; int rv; int rd; int mx;
  } vec_t;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int vis1();
    return (exp_q1.size() > 0 && rdy_q1[0] <= cyc) ? 1 : 0;
  endfunction

  function automatic void upd_err(int m, int wrej, int rrej, int cnt);
    if (wrej != 0) m_ovf[m] = 1;
    else if (clear_err) m_ovf[m] = 0;
    if (rrej != 0) m_udf[m] = 1;
    else if (clear_err) m_udf[m] = 0;
    if (clear_err || cnt > m_max[m]) m_max[m] = cnt;
  endfunction

  task automatic model_edge();
    int n;
    int v;
    v = vis1();
    cyc++;
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      rdy_q1.delete();
      m_rd0 = '0;
      m_rv0 = 0;
      for (int m = 0; m < 2; m++) begin
        m_ovf[m] = 0;
        m_udf[m] = 0;
        m_max[m] = 0;
      end
      return;
    end
    n = exp_q0.size();
    m_rv0 = (read_en && n > 0) ? 1 : 0;
    if (m_rv0 != 0) m_rd0 = exp_q0.pop_front();
    if (write_en && n < DEPTH) exp_q0.push_back(write_data);
    upd_err(0, (write_en && n == DEPTH) ? 1 : 0, (read_en && n == 0) ? 1 : 0, exp_q0.size());
    n = exp_q1.size();
    if (read_en && v != 0) begin
      void'(exp_q1.pop_front());
      void'(rdy_q1.pop_front());
    end
    if (write_en && n < DEPTH) begin
      exp_q1.push_back(write_data);
      rdy_q1.push_back(cyc + 2);
    end
    upd_err(1, (write_en && n == DEPTH) ? 1 : 0, (read_en && v == 0) ? 1 : 0, exp_q1.size());
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      int    n;
      int    v;
      string p;
      n = (m == 0) ? exp_q0.size() : exp_q1.size();
      v = (m == 0) ? m_rv0 : vis1();
      p = (m == 0) ? "std" : "fwft";
      chk({p, ".count"}, 32'(o_cnt[m]), n);
      chk({p, ".free"},  32'(o_free[m]), DEPTH - n);
      chk({p, ".full"},  32'(o_full[m]), 32'(n == DEPTH));
      chk({p, ".empty"}, 32'(o_empty[m]), (m == 0) ? 32'(n == 0) : 32'(v == 0));
      chk({p, ".afull"}, 32'(o_af[m]), 32'((DEPTH - n) <= AFG));
      chk({p, ".aempty"}, 32'(o_ae[m]), 32'(n <= AEG));
      chk({p, ".ovf"},   32'(o_ovf[m]), m_ovf[m]);
      chk({p, ".udf"},   32'(o_udf[m]), m_udf[m]);
      chk({p, ".max"},   32'(o_max[m]), m_max[m]);
      chk({p, ".valid"}, 32'(o_rv[m]), v);
      if (m == 0) chk("std.data", 32'(o_rd[0]), 32'(m_rd0));
      else if (v != 0) chk("fwft.data", 32'(o_rd[1]), 32'(exp_q1[0]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    write_en = 1'b0;
    read_en = 1'b0;
    clear_err = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input int d);
    write_en = 1'b1;
    write_data = 8'(d);
    tick();
    write_en = 1'b0;
  endtask

  task automatic pop();
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
  endtask

  initial begin
    int pw_tab [4];
    int pr_tab [4];
    pw_tab = '{75, 25, 55, 90};
    pr_tab = '{35, 75, 55, 90};
    rst_n = 1'b0;
    write_en = 1'b0;
    read_en = 1'b0;
    clear_err = 1'b0;
    write_data = '0;

    //          we wd    re clr  cnt full emp af ae ovf udf rv rd   mx
    tbl[0]  = '{1, 'h01, 0, 0,   1,  0,   0,  0, 1, 0,  0,  0, 'h00, 1};
    tbl[1]  = '{1, 'h02, 0, 0,   2,  0,   0,  0, 0, 0,  0,  0, 'h00, 2};
    tbl[2]  = '{1, 'h03, 0, 0,   3,  0,   0,  0, 0, 0,  0,  0, 'h00, 3};
    tbl[3]  = '{1, 'h04, 0, 0,   4,  0,   0,  1, 0, 0,  0,  0, 'h00, 4};
    tbl[4]  = '{1, 'h05, 0, 0,   5,  0,   0,  1, 0, 0,  0,  0, 'h00, 5};
    tbl[5]  = '{1, 'h06, 0, 0,   6,  1,   0,  1, 0, 0,  0,  0, 'h00, 6};
    tbl[6]  = '{1, 'h07, 0, 0,   6,  1,   0,  1, 0, 1,  0,  0, 'h00, 6};
    tbl[7]  = '{0, 'h00, 1, 0,   5,  0,   0,  1, 0, 1,  0,  1, 'h01, 6};
    tbl[8]  = '{0, 'h00, 1, 0,   4,  0,   0,  1, 0, 1,  0,  1, 'h02, 6};
    tbl[9]  = '{0, 'h00, 1, 0,   3,  0,   0,  0, 0, 1,  0,  1, 'h03, 6};
    tbl[10] = '{0, 'h00, 1, 0,   2,  0,   0,  0, 0, 1,  0,  1, 'h04, 6};
    tbl[11] = '{0, 'h00, 1, 0,   1,  0,   0,  0, 1, 1,  0,  1, 'h05, 6};
    tbl[12] = '{0, 'h00, 1, 0,   0,  0,   1,  0, 1, 1,  0,  1, 'h06, 6};
    tbl[13] = '{0, 'h00, 1, 0,   0,  0,   1,  0, 1, 1,  1,  0, 'h06, 6};
    tbl[14] = '{0, 'h00, 0, 1,   0,  0,   1,  0, 1, 0,  0,  0, 'h06, 0};
    tbl[15] = '{0, 'h00, 0, 0,   0,  0,   1,  0, 1, 0,  0,  0, 'h06, 0};

    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      chk("rst.count", 32'(o_cnt[m]), 0);
      chk("rst.free", 32'(o_free[m]), DEPTH);
      chk("rst.empty", 32'(o_empty[m]), 1);
      chk("rst.full", 32'(o_full[m]), 0);
      chk("rst.afull", 32'(o_af[m]), 0);
      chk("rst.aempty", 32'(o_ae[m]), 1);
      chk("rst.valid", 32'(o_rv[m]), 0);
      chk("rst.max", 32'(o_max[m]), 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      write_en = 1'(tbl[i].we);
      write_data = 8'(tbl[i].wd);
      read_en = 1'(tbl[i].re);
      clear_err = 1'(tbl[i].clr);
      tick();
      chk($sformatf("tbl%0d.count", i), 32'(o_cnt[0]), tbl[i].cnt);
      chk($sformatf("tbl%0d.full", i), 32'(o_full[0]), tbl[i].full);
      chk($sformatf("tbl%0d.empty", i), 32'(o_empty[0]), tbl[i].empty);
      chk($sformatf("tbl%0d.afull", i), 32'(o_af[0]), tbl[i].af);
      chk($sformatf("tbl%0d.aempty", i), 32'(o_ae[0]), tbl[i].ae);
      chk($sformatf("tbl%0d.ovf", i), 32'(o_ovf[0]), tbl[i].ovf);
      chk($sformatf("tbl%0d.udf", i), 32'(o_udf[0]), tbl[i].udf);
      chk($sformatf("tbl%0d.valid", i), 32'(o_rv[0]), tbl[i].rv);
      chk($sformatf("tbl%0d.data", i), 32'(o_rd[0]), tbl[i].rd);
      chk($sformatf("tbl%0d.max", i), 32'(o_max[0]), tbl[i].mx);
    end
    write_en = 1'b0;
    read_en = 1'b0;
    clear_err = 1'b0;

    // Pointer wrap at constant occupancy of three.
    do_reset();
    for (int k = 0; k < 3; k++) push('h10 + k);
    tick();
    tick();
    for (int k = 0; k < 40; k++) begin
      write_en = 1'b1;
      read_en = 1'b1;
      write_data = 8'('h13 + k);
      tick();
      chk("wrap.std_count", 32'(o_cnt[0]), 3);
      chk("wrap.std_data", 32'(o_rd[0]), 'h10 + k);
      chk("wrap.fwft_count", 32'(o_cnt[1]), 3);
      chk("wrap.fwft_data", 32'(o_rd[1]), 'h11 + k);
    end
    write_en = 1'b0;
    read_en = 1'b0;

    // FWFT fill latency and pop-to-empty.
    do_reset();
    push('hA5);
    chk("fwft_lat.edge_n", 32'(o_rv[1]), 0);
    tick();
    chk("fwft_lat.edge_n1", 32'(o_rv[1]), 0);
    tick();
    chk("fwft_lat.edge_n2_valid", 32'(o_rv[1]), 1);
    chk("fwft_lat.edge_n2_data", 32'(o_rd[1]), 'hA5);
    chk("fwft_lat.edge_n2_empty", 32'(o_empty[1]), 0);
    pop();
    chk("fwft_pop.valid", 32'(o_rv[1]), 0);
    chk("fwft_pop.empty", 32'(o_empty[1]), 1);
    chk("fwft_pop.count", 32'(o_cnt[1]), 0);

    // Watermark and clear_err.
    do_reset();
    pop();
    for (int k = 0; k < 5; k++) push('h40 + k);
    for (int k = 0; k < 4; k++) pop();
    for (int m = 0; m < 2; m++) begin
      chk("wm.max_peak", 32'(o_max[m]), 5);
      chk("wm.count", 32'(o_cnt[m]), 1);
      chk("wm.udf_set", 32'(o_udf[m]), 1);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("wm.max_cleared", 32'(o_max[m]), 1);
      chk("wm.udf_cleared", 32'(o_udf[m]), 0);
      chk("wm.ovf_cleared", 32'(o_ovf[m]), 0);
    end

    // Empty with write+read, reset mid-operation, full with write+read.
    do_reset();
    write_en = 1'b1;
    read_en = 1'b1;
    write_data = 8'h77;
    tick();
    read_en = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("empty_wr_rd.count", 32'(o_cnt[m]), 1);
      chk("empty_wr_rd.udf", 32'(o_udf[m]), 1);
    end
    for (int k = 0; k < 3; k++) push('h20 + k);
    rst_n = 1'b0;
    write_en = 1'b1;
    read_en = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      chk("mid_rst.count", 32'(o_cnt[m]), 0);
      chk("mid_rst.empty", 32'(o_empty[m]), 1);
      chk("mid_rst.valid", 32'(o_rv[m]), 0);
      chk("mid_rst.free", 32'(o_free[m]), DEPTH);
    end
    rst_n = 1'b1;
    read_en = 1'b0;
    push('h55);
    for (int m = 0; m < 2; m++) chk("post_rst.count", 32'(o_cnt[m]), 1);
    for (int k = 0; k < 5; k++) push('h60 + k);
    for (int m = 0; m < 2; m++) chk("fill.full", 32'(o_full[m]), 1);
    write_en = 1'b1;
    read_en = 1'b1;
    write_data = 8'hEE;
    tick();
    write_en = 1'b0;
    read_en = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("full_wr_rd.count", 32'(o_cnt[m]), 5);
      chk("full_wr_rd.ovf", 32'(o_ovf[m]), 1);
      chk("full_wr_rd.full", 32'(o_full[m]), 0);
    end
    chk("full_wr_rd.std_data", 32'(o_rd[0]), 'h55);

    // Randomized traffic with varying write/read bias and occasional resets.
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 700; c++) begin
        rst_n = ($urandom_range(0, 399) != 0);
        write_en = ($urandom_range(0, 99) < pw_tab[seg]);
        read_en = ($urandom_range(0, 99) < pr_tab[seg]);
        clear_err = ($urandom_range(0, 99) < 3);
        write_data = 8'($urandom);
        tick();
      end
    end
    rst_n = 1'b1;
    write_en = 1'b0;
    read_en = 1'b0;
    clear_err = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
